uart_rx_arq: RTL

- Serial receiver paired with the UART_Tx transmitter on the same baud clock, one line sample per clock.
- Frame format:
  - start bit (0)
  - `size` data bits, LSB first
  - even parity bit
  - stop bit (1)
- Checks parity and drives `Flag_out` back to the transmitter's `Flag_in`, requesting a data resend on mismatch.
- On a good frame, presents the parallel word with a one-cycle `DoneRx` strobe.

---
 rtl/uart_defs.sv | 15 +
 rtl/parity_acc.sv | 26 ++
 rtl/uart_rx_arq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions: frame FSM state encodings, parity convention and default word size.
package uart_defs;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DATA       = 3'd1;
  localparam logic [2:0] ST_PARITY_CHK = 3'd2;
  localparam logic [2:0] ST_RESYNC     = 3'd3;
  localparam logic [2:0] ST_STOP       = 3'd4;

  // Even parity: the parity bit equals the XOR of the data bits.
  localparam logic PARITY_ODD = 1'b0;

  localparam int DEFAULT_SIZE = 32;

endpackage

// File: rtl/parity_acc.sv
// Running XOR of serial bits with synchronous clear (priority) and enable.
module parity_acc (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic acc_o
);

  logic acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = 1'b0;
    else if (en_i) acc_d = acc_q ^ bit_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= 1'b0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/uart_rx_arq.sv
// UART receiver with even-parity check and resend request (ARQ) back to the transmitter.
// Optional error counter output enabled by defining UART_RX_ERR_CNT_EN.
import uart_defs::*;

module uart_rx_arq #(
  parameter int size      = DEFAULT_SIZE,
  parameter int MAX_RETRY = 3
) (
  input  logic            CLK_Baudin,
  input  logic            RstRx,
  input  logic            RxSerialData,
  output logic [size-1:0] DataOut,
  output logic            DoneRx,
  output logic            Flag_out,
  output logic            ParityErr,
  output logic            FrameErr
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]      ErrCount
`endif
);

  localparam int BCW = $clog2(size + 1);
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [2:0]      state_q, state_d;
  logic [BCW-1:0]  bitcnt_q, bitcnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [size-1:0] shreg_q, shreg_d;
  logic [size-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            acc_clr, acc_en, acc;
  logic            mismatch, flag;

  parity_acc u_parity_acc (
    .clk_i (CLK_Baudin),
    .rst_i (RstRx),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .bit_i (RxSerialData),
    .acc_o (acc)
  );

  // Combinational so the transmitter sees the request on the same edge it samples.
  assign mismatch = RxSerialData ^ acc ^ PARITY_ODD;
  assign flag     = (state_q == ST_PARITY_CHK) && mismatch && (int'(retry_q) < MAX_RETRY);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    retry_d  = retry_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!RxSerialData) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
          shreg_d  = '0;
          acc_clr  = 1'b1;
        end
      end
      ST_DATA: begin
        shreg_d  = {RxSerialData, shreg_q[size-1:1]};
        acc_en   = 1'b1;
        bitcnt_d = bitcnt_q + BCW'(1);
        if (bitcnt_q == BCW'(size - 1)) state_d = ST_PARITY_CHK;
      end
      ST_PARITY_CHK: begin
        if (flag) begin
          retry_d = retry_q + RW'(1);
          state_d = ST_RESYNC;
        end else begin
          perr_d  = mismatch;
          state_d = ST_STOP;
        end
      end
      ST_RESYNC: begin
        // The resend follows directly with no start bit.
        bitcnt_d = '0;
        acc_clr  = 1'b1;
        state_d  = ST_DATA;
      end
      ST_STOP: begin
        ferr_d  = ~RxSerialData;
        dout_d  = shreg_q;
        done_d  = 1'b1;
        retry_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_Baudin) begin
    if (RstRx) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      retry_q  <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      retry_q  <= retry_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_ff @(posedge CLK_Baudin) begin
    shreg_q <= shreg_d;
  end

  assign DataOut   = dout_q;
  assign DoneRx    = done_q;
  assign Flag_out  = flag;
  assign ParityErr = perr_q;
  assign FrameErr  = ferr_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] errcnt_q, errcnt_d;
  logic       err_inc;

  assign err_inc = flag || ((state_q == ST_STOP) && (perr_q || !RxSerialData));

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_inc && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge CLK_Baudin) begin
    if (RstRx) errcnt_q <= 8'd0;
    else       errcnt_q <= errcnt_d;
  end

  assign ErrCount = errcnt_q;
`endif

endmodule
